// File: rtl/watch_pkg.sv
// Shared definitions for the watch/stopwatch digit datapath: run-state encoding,
// BCD constants and the common per-digit moduli.
package watch_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } run_state_e;

  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_NINE = 4'd9;

  localparam int SEC_UNITS  = 10;
  localparam int SEC_TENS   = 6;
  localparam int MIN_UNITS  = 10;
  localparam int MIN_TENS   = 6;
  localparam int HOUR_TENS  = 3;

  localparam int MODULO_MIN = 2;
  localparam int MODULO_MAX = 16;

  function automatic bit is_valid_modulo(input int m);
    return (m >= MODULO_MIN) && (m <= MODULO_MAX);
  endfunction

endpackage

// File: rtl/digit_run_ctrl.sv
// Run-control FSM for one counter digit: STOPPED / RUNNING / PAUSED.
// clear beats stop, stop beats start_resume; running is a registered copy of RUNNING.
module digit_run_ctrl
  import watch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_resume,
  input  logic       stop,
  input  logic       clear,
  output run_state_e state,
  output logic       running
);

  run_state_e state_q;
  run_state_e state_d;
  logic       running_q;

  always_comb begin
    // An unreachable encoding falls back to STOPPED.
    state_d = (state_q inside {STOPPED, RUNNING, PAUSED}) ? state_q : STOPPED;
    if (clear) begin
      state_d = STOPPED;
    end else if (stop) begin
      if (state_q == RUNNING) state_d = PAUSED;
    end else if (start_resume && (state_q != RUNNING)) begin
      state_d = RUNNING;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= STOPPED;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUNNING);
    end
  end

  assign state   = state_q;
  assign running = running_q;

endmodule

// File: rtl/mod_n_digit_counter.sv
// Single modulo-MODULO display digit with run control, load/clear and same-cycle carry.
// Define DIGIT_COUNTER_DOWN_EN to honour dir (down-count with borrow carry at 0).
module mod_n_digit_counter
  import watch_pkg::*;
#(
  parameter int MODULO = 6,
  parameter int WIDTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_resume,
  input  logic             stop,
  input  logic             clear,
  input  logic             tick_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dir,
  output logic [WIDTH-1:0] number,
  output logic             carry_out,
  output logic             running,
  output logic             load_err
);

  generate
    if (!is_valid_modulo(MODULO) || ((2 ** WIDTH) < MODULO)) begin : g_bad_cfg
      $error("mod_n_digit_counter: MODULO=%0d does not fit WIDTH=%0d or is outside 2..16",
             MODULO, WIDTH);
    end
  endgenerate

  localparam logic [WIDTH-1:0] TOP_VAL  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULO);

  run_state_e       state;
  logic [WIDTH-1:0] count_q, count_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] step_val;
  logic             at_term;
  logic             tick_en;
  logic             load_ok;

  digit_run_ctrl u_run_ctrl (
    .clk          (clk),
    .reset        (reset),
    .start_resume (start_resume),
    .stop         (stop),
    .clear        (clear),
    .state        (state),
    .running      (running)
  );

`ifdef DIGIT_COUNTER_DOWN_EN
  always_comb begin
    if (dir) begin
      at_term  = (count_q == ZERO_VAL);
      step_val = at_term ? TOP_VAL : (count_q - WIDTH'(1));
    end else begin
      at_term  = (count_q == TOP_VAL);
      step_val = at_term ? ZERO_VAL : (count_q + WIDTH'(1));
    end
  end
`else
  logic unused_dir;
  assign unused_dir = dir;

  always_comb begin
    at_term  = (count_q == TOP_VAL);
    step_val = at_term ? ZERO_VAL : (count_q + WIDTH'(1));
  end
`endif

  assign tick_en = (state == RUNNING) && tick_in;
  assign load_ok = ({1'b0, load_value} < MOD_EXT);

  always_comb begin
    count_d    = count_q;
    load_err_d = 1'b0;
    if (clear) begin
      count_d = ZERO_VAL;
    end else if (load) begin
      // An out-of-range load still wins over a tick: the count simply holds.
      if (load_ok) count_d = load_value;
      else         load_err_d = 1'b1;
    end else if (tick_en) begin
      count_d = step_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= ZERO_VAL;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

  assign number    = count_q;
  assign load_err  = load_err_q;
  assign carry_out = tick_en && !clear && !load && at_term;

endmodule

// File: doc/mod_n_digit_counter.md
# mod_n_digit_counter

Parametrised single-digit modulo-N counter for the watch/stopwatch datapath, generalising the fixed mod-6 seconds-tens digit. Adds an explicit run-control FSM (stopped/running/paused), a cascade tick input, synchronous clear and load, and a same-cycle terminal-count carry so digits chain into seconds, minutes and hours. Each display digit (mod-10, mod-6, mod-3/mod-4 hours) is one instance of this block.

## Interface
- MODULO, default 6: count range 0..MODULO-1; legal values 2..16.
- WIDTH, default 4: count width; must satisfy 2**WIDTH >= MODULO (elaboration error otherwise).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start_resume  input  1  level-sampled request: STOPPED/PAUSED -> RUNNING.
- stop  input  1  request: RUNNING -> PAUSED.
- clear  input  1  synchronous: count := 0, state := STOPPED.
- tick_in  input  1  count-enable pulse (base tick or lower digit's carry_out).
- load  input  1  synchronous load of load_value.
- load_value  input  WIDTH  value for load.
- dir  input  1  0 = up, 1 = down (honoured only with DIGIT_COUNTER_DOWN_EN).
- number  output  WIDTH  registered count.
- carry_out  output  1  combinational terminal-count pulse for next digit.
- running  output  1  registered; 1 in RUNNING.
- load_err  output  1  registered one-cycle pulse on rejected load.

## Operation
- FSM states STOPPED, RUNNING, PAUSED; reset -> STOPPED.
- Transitions per edge, priority order: clear -> STOPPED; stop & RUNNING -> PAUSED; start_resume & (STOPPED|PAUSED) -> RUNNING; else hold. stop and start_resume together: stop wins (PAUSED stays PAUSED, STOPPED stays STOPPED).
- Count update priority: clear > load > count > hold.
- Count step: RUNNING & tick_in. Up: MODULO-1 -> 0, else +1. Down: 0 -> MODULO-1, else -1.
- carry_out = RUNNING & tick_in & ~clear & ~load & (up ? number==MODULO-1 : number==0). Suppressed in STOPPED/PAUSED.
- load: if load_value < MODULO, number := load_value in any state, state unchanged; else number unchanged and load_err pulses next cycle.
- number never leaves 0..MODULO-1.

## Timing
- Reset values: number=0, running=0, load_err=0, state STOPPED; carry_out=0 (follows from state).
- Asynchronous assertion, synchronous-to-clk use after deassertion; reset mid-count discards count immediately.
- Count latency: tick_in high at edge N -> new number visible after edge N.
- carry_out valid in the same cycle as the wrapping tick, so a cascaded digit increments on the same edge the lower digit wraps; no ripple delay per stage.
- start_resume at edge N: counting begins with ticks sampled at edge N+1; a tick coincident with start_resume is not counted.
- stop at edge N: a tick coincident with stop is still counted (state was RUNNING).
- load_err: one cycle after offending load.

## Configuration
- DIGIT_COUNTER_DOWN_EN defined: dir honoured, down-counting and borrow-style carry_out at 0 (countdown timer mode).
- Not defined: dir port present but ignored; up-count only; down-wrap logic not synthesised.

## Structure
- Shared package watch_pkg: run-state encoding (STOPPED=2'b00, RUNNING=2'b01, PAUSED=2'b10), BCD constants, common MODULO values (SEC_UNITS=10, SEC_TENS=6).
- One sub-module: digit_run_ctrl (FSM: start_resume/stop/clear -> state, running). Count datapath stays in the top.

## Test plan
- Reset low mid-count at number=4 -> number=0, running=0 immediately; after release, start_resume then 6 ticks (MODULO=6) -> 1,2,3,4,5,0, carry_out high only on the tick at 5.
- Two instances (MODULO=10 feeding MODULO=6), 60 ticks -> lower wraps 6 times, upper reaches 0 at tick 60 with carry_out high that same cycle.
- RUNNING at 3, stop+tick same edge -> 4, PAUSED; further ticks -> stays 4, carry_out 0; start_resume -> resumes 5.
- load_value=7 with MODULO=6 -> number unchanged, load_err pulse next cycle; load_value=2 while PAUSED -> number=2, still PAUSED.
- clear+load+tick same edge at number=5 -> number=0, STOPPED, carry_out 0.
- With DIGIT_COUNTER_DOWN_EN, dir=1 from 1: ticks -> 0 then 5 with carry_out on the 0->5 tick; without macro, dir=1 -> still counts up.
